// File: rtl/mips_datapath.sv
// mips_datapath: single-cycle 32-bit MIPS-style datapath without a control unit.
// PC, instruction ROM, 32x32 register file, sign extender, ALU and data RAM.
// All control signals are supplied externally; every instruction retires in one clock.
module mips_datapath #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_en,
    input  logic        reg_dst,
    input  logic        alu_src,
    input  logic [2:0]  alu_ctrl,
    input  logic        mem_write_en,
    input  logic        mem_to_reg,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result
);

    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    logic [31:0] pc;
    logic [25:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  wa;
    logic [31:0] regs [32];
    logic [31:0] ram [DMEM_DEPTH] = '{default: '0};
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] src_b;
    logic [31:0] ram_rd;
    logic [31:0] wb;

    // The opcode field is never decoded here (control comes from outside),
    // so the ROM only stores instruction bits [25:0]:
    // addi $t0,$0,5 / addi $t1,$0,10 / add $t2,$t0,$t1 / sw $t2,4($0)
    function automatic logic [25:0] rom_word(input logic [IA-1:0] addr);
        case (int'(addr))
            0:       rom_word = 26'h0080005;
            1:       rom_word = 26'h009000A;
            2:       rom_word = 26'h1095020;
            3:       rom_word = 26'h00A0004;
            default: rom_word = 26'h0000000;
        endcase
    endfunction

    assign pc_out = pc;
    assign instr  = rom_word(pc[IA+1:2]);
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign wa     = reg_dst ? rd : rt;

    assign rd1    = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rd2    = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign imm    = {{16{instr[15]}}, instr[15:0]};
    assign src_b  = alu_src ? imm : rd2;

    assign ram_rd = ram[alu_result[DA+1:2]];
    assign wb     = mem_to_reg ? ram_rd : alu_result;

    // Program counter: advances by one word every clock, no branches, wraps at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    // Register file write port; R0 is never written so it always holds zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_write_en && (wa != 5'd0)) begin
            regs[wa] <= wb;
        end
    end

    // Data RAM write port; contents survive reset, only the power-up value is zero
    always_ff @(posedge clk) begin
        if (mem_write_en && !rst) begin
            ram[alu_result[DA+1:2]] <= rd2;
        end
    end

    // ALU: unlisted operation codes produce zero, arithmetic wraps silently
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            3'b000:  alu_result = rd1 & src_b;
            3'b001:  alu_result = rd1 | src_b;
            3'b010:  alu_result = rd1 + src_b;
            3'b110:  alu_result = rd1 - src_b;
            3'b111:  alu_result = {31'd0, ($signed(rd1) < $signed(src_b))};
            default: alu_result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mips_datapath.sv
// tb_mips_datapath: directed program walk-through followed by randomized control
// sequences, checked against an architectural model of the datapath.
module tb_mips_datapath;

    logic        clk;
    logic        rst;
    logic        reg_write_en;
    logic        reg_dst;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        mem_write_en;
    logic        mem_to_reg;
    logic [31:0] pc_out;
    logic [31:0] alu_result;

    int compared   = 0;
    int mismatched = 0;

    // Architectural state of the reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_ram  [64];
    logic [31:0] m_rom  [64];
    logic [31:0] m_pc;

    mips_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_en (reg_write_en),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .alu_ctrl     (alu_ctrl),
        .mem_write_en (mem_write_en),
        .mem_to_reg   (mem_to_reg),
        .pc_out       (pc_out),
        .alu_result   (alu_result)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] modelInstr();
        return m_rom[(m_pc / 4) % 64];
    endfunction

    function automatic logic [31:0] modelReg(input logic [31:0] idx);
        return m_regs[idx % 32];
    endfunction

    function automatic logic [31:0] modelAlu();
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ext;
        ins = modelInstr();
        a   = modelReg(ins / 32'h0020_0000);
        ext = ins % 32'h0001_0000;
        if (ext >= 32'h0000_8000) ext = ext + 32'hFFFF_0000;
        b   = alu_src ? ext : modelReg(ins / 32'h0001_0000);
        case (alu_ctrl)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic modelCommit();
        logic [31:0] ins;
        logic [31:0] res;
        logic [31:0] store_val;
        logic [31:0] wb;
        int          ram_idx;
        int          dest;
        ins       = modelInstr();
        res       = modelAlu();
        ram_idx   = int'((res / 4) % 64);
        store_val = modelReg(ins / 32'h0001_0000);
        wb        = mem_to_reg ? m_ram[ram_idx] : res;
        dest      = reg_dst ? int'((ins / 32'h0000_0800) % 32) : int'((ins / 32'h0001_0000) % 32);
        if (mem_write_en) m_ram[ram_idx] = store_val;
        if (reg_write_en && dest != 0) m_regs[dest] = wb;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic dst, input logic src,
                                 input logic [2:0] ctrl, input logic mwe, input logic m2r);
        reg_write_en = we;
        reg_dst      = dst;
        alu_src      = src;
        alu_ctrl     = ctrl;
        mem_write_en = mwe;
        mem_to_reg   = m2r;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_pc"}, pc_out, m_pc);
        checkValue({tag, "_alu"}, alu_result, modelAlu());
    endtask

    task automatic clockTick();
        @(posedge clk);
        if (rst) modelReset();
        else     modelCommit();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_rom[i] = 32'd0;
            m_ram[i] = 32'd0;
        end
        m_rom[0] = 32'h2008_0005;
        m_rom[1] = 32'h2009_000A;
        m_rom[2] = 32'h0109_5020;
        m_rom[3] = 32'hAC0A_0004;
        modelReset();

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        checkValue("reset_pc", pc_out, 32'd0);
        checkOutput("reset");
        rst = 1'b0;

        $display("[TB] running preloaded program");
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        checkValue("addi_t0_alu", alu_result, 32'd5);
        checkOutput("addi_t0");
        clockTick();
        checkValue("pc_after_t0", pc_out, 32'd4);

        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        checkValue("addi_t1_alu", alu_result, 32'd10);
        clockTick();
        checkValue("pc_after_t1", pc_out, 32'd8);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
        checkValue("add_t2_alu", alu_result, 32'd15);
        clockTick();
        checkValue("pc_after_t2", pc_out, 32'd12);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
        checkValue("sw_addr_alu", alu_result, 32'd4);
        clockTick();

        // Idle through the empty ROM words until the PC wraps onto word 0 again
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0, 1'b0);
            checkOutput("idle1");
            clockTick();
        end

        // rd field of addi is 0, so reg_dst=1 aims the write at R0
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        checkValue("r0_write_alu", alu_result, 32'd5);
        checkOutput("r0_write");
        clockTick();

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        checkValue("r0_reads_zero", alu_result, 32'd10);
        clockTick();

        applyStimulus(1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);
        checkValue("sub_5_10", alu_result, 32'hFFFF_FFFB);
        clockTick();

        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0, 1'b0);
            checkOutput("idle2");
            clockTick();
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
        checkValue("slt_5_10", alu_result, 32'd1);
        checkOutput("slt");

        // Asynchronous reset mid-cycle while the PC sits at 8
        rst = 1'b1;
        #1;
        modelReset();
        checkValue("async_rst_pc", pc_out, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
        checkValue("rst_regs_clear", alu_result, 32'd0);
        clockTick();
        rst = 1'b0;

        // Load RAM word 1 into $t0 to show the stored 15 survived reset
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
        checkValue("ram_rd_addr", alu_result, 32'd5);
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        checkOutput("after_load");
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        checkValue("ram_kept", alu_result, 32'd15);
        clockTick();

        $display("[TB] randomized control sequence");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
                modelReset();
                checkValue("rand_rst_pc", pc_out, 32'd0);
                clockTick();
                rst = 1'b0;
            end else begin
                applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                              1'($urandom), 1'($urandom));
                checkOutput("rand");
                clockTick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
